// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the fetch stage and its neighbours.
// Contents: pc_t / instr_t word types, the bubble instruction, the default
// reset vector and the sequential PC increment.
package cpu_pkg;

    typedef logic [31:0] pc_t;
    typedef logic [31:0] instr_t;

    // sll $0,$0,0
    localparam instr_t NOP_INSTR        = 32'h0000_0000;
    localparam pc_t    DEFAULT_RESET_PC = 32'h0000_0000;
    localparam pc_t    PC_STEP          = 32'd4;

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory fetch bus between the IF stage and instruction memory.
//   imem_addr  : fetch address (driven by the fetch stage, combinational)
//   imem_rdata : instruction word at imem_addr
//   imem_ready : imem_rdata is valid this cycle
// master = fetch stage, slave = instruction memory.
interface if_stage_if;
    import cpu_pkg::*;

    pc_t    imem_addr;
    instr_t imem_rdata;
    logic   imem_ready;

    modport master (output imem_addr, input imem_rdata, input imem_ready);
    modport slave  (input imem_addr, output imem_rdata, output imem_ready);

endinterface

// File: rtl/if_stage_ifid_reg.sv
// IF/ID pipeline register: instruction word, its PC+4 and a valid bit.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   flush           : load a bubble (dominates everything)
//   hold            : keep current contents
//   load            : capture instr_in / pc_plus4_in as a valid instruction
//   instr_in        : incoming instruction word
//   pc_plus4_in     : incoming PC+4
//   instr, pc_plus4, valid : registered outputs
// With none of flush/hold/load asserted the register takes a bubble.
module ifid_reg
    import cpu_pkg::*;
#(
    parameter instr_t NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   flush,
    input  logic   hold,
    input  logic   load,
    input  instr_t instr_in,
    input  pc_t    pc_plus4_in,
    output instr_t instr,
    output pc_t    pc_plus4,
    output logic   valid
);

    instr_t instr_q,    instr_d;
    pc_t    pc_plus4_q, pc_plus4_d;
    logic   valid_q,    valid_d;

    always_comb begin
        instr_d    = NOP_INSTR;
        pc_plus4_d = '0;
        valid_d    = 1'b0;
        if (flush) begin
            instr_d    = NOP_INSTR;
            pc_plus4_d = '0;
            valid_d    = 1'b0;
        end else if (hold) begin
            instr_d    = instr_q;
            pc_plus4_d = pc_plus4_q;
            valid_d    = valid_q;
        end else if (load) begin
            instr_d    = instr_in;
            pc_plus4_d = pc_plus4_in;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            valid_q    <= valid_d;
        end
    end

    assign instr    = instr_q;
    assign pc_plus4 = pc_plus4_q;
    assign valid    = valid_q;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC and the
// IF/ID register.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem (master)     : imem_addr = pc (combinational), imem_rdata, imem_ready
//   stall             : hold PC and IF/ID (load-use hazard)
//   redirect_valid    : control transfer resolved this cycle
//   redirect_target   : new PC (low two bits ignored)
//   pc                : current fetch PC
//   ifid_instr        : registered instruction to decode
//   ifid_pc_plus4     : registered PC+4 of ifid_instr
//   ifid_valid        : ifid_instr is real, not a bubble
// Optional (macro IF_PERF_CNT_EN): perf_fetch_cnt, perf_stall_cnt,
// perf_flush_cnt, 32-bit saturating event counters.
// Edge priority: redirect > stall > !imem_ready > sequential fetch.
module if_stage
    import cpu_pkg::*;
#(
    parameter pc_t    RESET_PC  = DEFAULT_RESET_PC,
    parameter instr_t NOP_INSTR = cpu_pkg::NOP_INSTR
) (
    input  logic              clk,
    input  logic              rst_n,
    if_stage_if.master        imem,
    input  logic              stall,
    input  logic              redirect_valid,
    input  pc_t               redirect_target,
    output pc_t               pc,
    output instr_t            ifid_instr,
    output pc_t               ifid_pc_plus4,
    output logic              ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    pc_t  pc_q, pc_d;
    pc_t  pc_plus4;
    logic unused_tgt_bits;

    // Word alignment: the byte offset of a redirect target is dropped.
    assign unused_tgt_bits = ^redirect_target[1:0];

    assign pc_plus4       = pc_q + PC_STEP;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_valid) begin
            pc_d = {redirect_target[31:2], 2'b00};
        end else if (!stall && imem.imem_ready) begin
            pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // A redirect discards the wrong-path word regardless of stall/ready;
    // a missing imem response falls through to the bubble default.
    ifid_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_ifid_reg (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (redirect_valid),
        .hold        (stall),
        .load        (imem.imem_ready),
        .instr_in    (imem.imem_rdata),
        .pc_plus4_in (pc_plus4),
        .instr       (ifid_instr),
        .pc_plus4    (ifid_pc_plus4),
        .valid       (ifid_valid)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (redirect_valid) begin
            if (perf_flush_q != '1) perf_flush_d = perf_flush_q + 32'd1;
        end else if (stall || !imem.imem_ready) begin
            if (perf_stall_q != '1) perf_stall_d = perf_stall_q + 32'd1;
        end else begin
            if (perf_fetch_q != '1) perf_fetch_d = perf_fetch_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] pc;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (32'h0000_0000)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem            (bus.master),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .pc              (pc),
        .ifid_instr      (ifid_instr),
        .ifid_pc_plus4   (ifid_pc_plus4),
        .ifid_valid      (ifid_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt  (perf_fetch_cnt),
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_flush_cnt  (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Instruction memory contents: address 0 holds addi, others a scramble.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h2008_0005;
        return {a[15:0] ^ 16'h3C1D, ~a[31:16]} + 32'h1357_9BDF;
    endfunction

    assign bus.imem_rdata = mem_word(bus.imem_addr);

    // Reference model of the architectural state.
    logic [31:0] m_pc, m_instr, m_pp4;
    logic        m_valid;
    logic [31:0] m_fetch, m_stall, m_flush;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            m_fetch = 0; m_stall = 0; m_flush = 0;
        end else if (redirect_valid) begin
            m_pc = redirect_target & 32'hFFFF_FFFC;
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            if (m_flush != 32'hFFFF_FFFF) m_flush = m_flush + 1;
        end else if (stall) begin
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end else if (!bus.imem_ready) begin
            m_instr = 32'h0; m_pp4 = 32'h0; m_valid = 1'b0;
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end else begin
            m_instr = mem_word(m_pc);
            m_pp4   = m_pc + 32'd4;
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
            if (m_fetch != 32'hFFFF_FFFF) m_fetch = m_fetch + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    logic model_on = 1'b0;
    always @(negedge clk) begin
        if (model_on) begin
            check("m_pc",       pc,                 m_pc);
            check("m_addr",     bus.imem_addr,      m_pc);
            check("m_instr",    ifid_instr,         m_instr);
            check("m_pp4",      ifid_pc_plus4,      m_pp4);
            check("m_valid",    {31'b0, ifid_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
            check("m_fetchcnt", perf_fetch_cnt,     m_fetch);
            check("m_stallcnt", perf_stall_cnt,     m_stall);
            check("m_flushcnt", perf_flush_cnt,     m_flush);
`endif
        end
    end

    task automatic cyc(input logic s, input logic rv, input logic [31:0] tgt, input logic rdy);
        stall = s; redirect_valid = rv; redirect_target = tgt; bus.imem_ready = rdy;
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pc"},    pc,                  32'h0);
        check({tag, "_addr"},  bus.imem_addr,       32'h0);
        check({tag, "_instr"}, ifid_instr,          32'h0);
        check({tag, "_pp4"},   ifid_pc_plus4,       32'h0);
        check({tag, "_valid"}, {31'b0, ifid_valid}, 32'h0);
`ifdef IF_PERF_CNT_EN
        check({tag, "_fcnt"},  perf_fetch_cnt,      32'h0);
        check({tag, "_scnt"},  perf_stall_cnt,      32'h0);
        check({tag, "_xcnt"},  perf_flush_cnt,      32'h0);
`endif
    endtask

    initial begin
        rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0;
        redirect_target = 32'h0; bus.imem_ready = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_reset_vals("rst");
        model_on = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;

        // First fetch of addi at RESET_PC
        cyc(0, 0, 32'h0, 1);
        check("f1_instr", ifid_instr, 32'h2008_0005);
        check("f1_pp4",   ifid_pc_plus4, 32'd4);
        check("f1_valid", {31'b0, ifid_valid}, 32'd1);
        check("f1_pc",    pc, 32'd4);
        cyc(0, 0, 32'h0, 1);
        check("f2_pc",  pc, 32'd8);
        check("f2_pp4", ifid_pc_plus4, 32'd8);

        // Two-cycle stall at pc=8
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 32'h0, 1);
            check("st_pc",    pc, 32'd8);
            check("st_pp4",   ifid_pc_plus4, 32'd8);
            check("st_instr", ifid_instr, mem_word(32'd4));
        end
        cyc(0, 0, 32'h0, 1);
        check("f3_pc",  pc, 32'd12);
        check("f3_pp4", ifid_pc_plus4, 32'd12);
        cyc(0, 0, 32'h0, 1);
        check("f4_pc",  pc, 32'd16);
        check("f4_pp4", ifid_pc_plus4, 32'd16);

        // Redirect overrides stall; low target bits dropped
        cyc(1, 1, 32'h0000_0043, 1);
        check("rd_pc",    pc, 32'h40);
        check("rd_valid", {31'b0, ifid_valid}, 32'd0);
        check("rd_instr", ifid_instr, 32'h0);
        cyc(0, 0, 32'h0, 1);
        check("rd_fetch_pp4",   ifid_pc_plus4, 32'h44);
        check("rd_fetch_instr", ifid_instr, mem_word(32'h40));

        // imem not ready for three cycles
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 32'h0, 0);
            check("nr_pc",    pc, 32'h44);
            check("nr_valid", {31'b0, ifid_valid}, 32'd0);
        end
        cyc(0, 0, 32'h0, 1);
        check("nr_resume_pp4", ifid_pc_plus4, 32'h48);

        // PC wrap
        cyc(0, 1, 32'hFFFF_FFFF, 1);
        check("wr_pc0", pc, 32'hFFFF_FFFC);
        cyc(0, 0, 32'h0, 1);
        check("wr_pc",    pc, 32'h0);
        check("wr_pp4",   ifid_pc_plus4, 32'h0);
        check("wr_valid", {31'b0, ifid_valid}, 32'd1);

        // Randomized traffic, including back-to-back redirects
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 15),
                $urandom, ($urandom_range(0, 99) < 75));
        end

        // Asynchronous reset mid-cycle while a redirect is pending
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_1000;
        #2 rst_n = 1'b0;
        #1 check_reset_vals("arst");
        @(negedge clk);
        rst_n = 1'b1; stall = 1'b0; redirect_valid = 1'b0; bus.imem_ready = 1'b1;
        cyc(0, 0, 32'h0, 1);
        check("post_rst_instr", ifid_instr, 32'h2008_0005);
        for (int i = 0; i < 50; i++) begin
            cyc(($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 10),
                $urandom, ($urandom_range(0, 99) < 90));
        end

        model_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC and the IF/ID pipeline register.
- Drives the 32-bit instruction word consumed by the decode-stage controller, plus pc_plus4 for jal write-back.
- Accepts redirects (branch taken, j/jal, jr) and stall/wait requests.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0000, bubble instruction injected on flush or wait (sll $0,$0,0).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  32  fetch address; combinational, equal to the pc register.
- imem_rdata  in  32  instruction word for imem_addr, valid when imem_ready=1.
- imem_ready  in  1  instruction memory has valid data this cycle.
- stall  in  1  hazard unit: hold the PC and the IF/ID register (load-use).
- redirect_valid  in  1  control transfer resolved this cycle.
- redirect_target  in  32  new PC for the redirect.
- pc  out  32  current fetch PC.
- ifid_instr  out  32  registered instruction to decode.
- ifid_pc_plus4  out  32  registered PC+4 of ifid_instr.
- ifid_valid  out  1  ifid_instr is a real instruction, not a bubble.

Behaviour:
- Reset (async, rst_n=0), all outputs immediately:
  - pc=RESET_PC
  - ifid_instr=NOP_INSTR
  - ifid_pc_plus4=0
  - ifid_valid=0
- First edge after rst_n deasserts: latches imem_rdata for RESET_PC if imem_ready=1.
- imem_addr = pc, with no registering.
- pc_plus4 = pc + 32'd4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Per-edge priority, highest first:
  1. redirect_valid=1:
     - pc <= {redirect_target[31:2],2'b00}; low two bits are ignored.
     - IF/ID <= bubble (NOP_INSTR, valid=0, pc_plus4=0).
     - Overrides stall and imem_ready; the wrong-path instruction is discarded.
  2. stall=1: pc and the whole IF/ID register hold their values.
  3. imem_ready=0: pc holds; IF/ID <= bubble.
  4. Otherwise:
     - pc <= pc_plus4.
     - ifid_instr <= imem_rdata.
     - ifid_pc_plus4 <= pc_plus4.
     - ifid_valid <= 1.
- Fetch latency: one cycle from address presentation to ifid_instr.
- Redirect penalty: one bubble; the instruction in IF when the redirect arrives never reaches ID.
- Back-to-back redirects: each takes effect on its own edge; the last one wins.
- Reset asserted mid-stall or mid-redirect: reset dominates immediately; pending redirect is lost.
- No internal state beyond pc, the IF/ID register, and the optional counters. No FSM beyond the priority mux; the IF/ID valid bit acts as bubble/valid state.

Optional Feature:
- Macro IF_PERF_CNT_EN.
- When defined, adds three output ports, each a 32-bit saturating counter, reset to 0:
  - perf_fetch_cnt: +1 per edge taking case 4.
  - perf_stall_cnt: +1 per edge taking case 2 or 3.
  - perf_flush_cnt: +1 per edge taking case 1.
- Each counter saturates at 32'hFFFF_FFFF.
- When undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - typedef pc_t (logic [31:0]) and instr_t (logic [31:0]).
  - Constants NOP_INSTR, DEFAULT_RESET_PC, PC_STEP=4.
- One sub-module, ifid_reg:
  - Holds instr, pc_plus4 and valid.
  - Inputs: load, flush, hold.
  - Flush dominates hold.
- The PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset, then imem_ready=1 with imem_rdata=32'h2008_0005 (addi):
  - during reset: imem_addr=0;
  - after edge 1: ifid_instr=32'h2008_0005, ifid_pc_plus4=4, ifid_valid=1, pc=4.
- Sequential fetch of 4 words:
  - pc steps 0,4,8,12,16;
  - ifid_pc_plus4 tracks 4,8,12,16.
- stall=1 for 2 cycles at pc=8: pc stays 8, and ifid_instr/ifid_pc_plus4 are unchanged for both cycles.
- redirect_valid=1, target=32'h0000_0043, asserted together with stall=1:
  - next pc=32'h0000_0040;
  - ifid_valid=0, ifid_instr=0;
  - following edge fetches 0x40.
- imem_ready=0 for 3 cycles: pc holds; 3 bubbles with ifid_valid=0; fetch resumes at the same pc.
- Wrap and reset:
  - pc=32'hFFFF_FFFC -> next pc=0 and ifid_pc_plus4=0.
  - Assert rst_n=0 asynchronously mid-cycle: outputs go to reset values without waiting for a clock edge.
  - With IF_PERF_CNT_EN: counters read 0 after reset.
